dmem_responder: RTL and testbench

- Memory-side responder for the core's data-port cmd/rsp protocol (valid/ready command, flow-style response). It replaces the zero-latency combinational loopback used in simulation.
- Accepts one command at a time, registers it, and drives a word-indexed synchronous-access RAM helper port.
- Returns read data after a programmable latency, so the core's load/stall logic is exercised under realistic timing.
- Sits between the core's dcache port and the RAMHelper instance inside the simulation top.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, default address window, strobe/index/alignment helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [63:0] DMEM_BASE_ADDR = 64'h8000_0000;
  localparam logic [63:0] DMEM_RAM_BYTES = 64'h0800_0000;

  // Expand each byte strobe into a full byte of write mask.
  function automatic logic [63:0] wstrb_to_mask(input logic [7:0] wstrb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{wstrb[i]}};
    end
    return mask;
  endfunction

  // Word index: offset from the window base, modulo 2^64, bits [30:3].
  function automatic logic [27:0] addr_to_idx(input logic [63:0] addr,
                                              input logic [63:0] base);
    return 28'((addr - base) >> 3);
  endfunction

  // True when the low address bits are not aligned to 2^size bytes.
  // Sizes above 3 are reported as misaligned.
  function automatic logic misaligned(input logic [2:0] addr_lo,
                                      input logic [2:0] size);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = addr_lo[0];
      3'd2:    bad = |addr_lo[1:0];
      3'd3:    bad = |addr_lo[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder.sv
// Memory-side responder: registers one data-port command, drives a word-indexed RAM port,
// returns read data LATENCY cycles after the RAM issue (read accepted at T -> rsp at T+1+LATENCY).
// Backpressure: cmd_ready only in IDLE, one command outstanding; writes occupy 2 cycles, no rsp.
// Ports: clock/reset (sync, active-high); cmd_* valid/ready command in; rsp_* single-cycle
//   read response out; ram_* enable/index/write port out plus combinational ram_rdata in.
// Optional: DMEM_RANGE_CHECK_EN enables window/size/alignment checking with error responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter logic [63:0] RAM_BYTES = DMEM_RAM_BYTES,
  parameter int          LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_payload_addr,
  input  logic        cmd_payload_wen,
  input  logic [63:0] cmd_payload_wdata,
  input  logic [7:0]  cmd_payload_wstrb,
  input  logic [2:0]  cmd_payload_size,
  output logic        rsp_valid,
  output logic [63:0] rsp_payload_data,
  output logic        rsp_payload_error,
  output logic        ram_en,
  output logic [27:0] ram_idx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [2:0]  size_q;

  logic [63:0] data_q;      // read data captured at ISSUE
  logic        err_q;       // error status captured at ISSUE
  logic [63:0] rsp_data_q;  // presented data, only updated when a response fires
  logic        rsp_err_q;

  logic        acc_err;
  logic [63:0] rdata_fresh;

`ifdef DMEM_RANGE_CHECK_EN
  logic [63:0] offset;
  assign offset  = addr_q - BASE_ADDR;
  assign acc_err = (addr_q < BASE_ADDR) || (offset >= RAM_BYTES) ||
                   misaligned(addr_q[2:0], size_q);
`else
  // No checking: the index simply wraps within its 28-bit field.
  logic unused_size;
  assign unused_size = ^size_q;
  assign acc_err     = 1'b0;
`endif

  // Errored reads return zero instead of whatever the RAM port shows.
  assign rdata_fresh = acc_err ? 64'h0 : ram_rdata;

  // ---------------------------------------------------------------
  // State register (with latency counter)
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (wen_q) begin
          state_d = IDLE;
        end else if (LATENCY == 1) begin
          state_d = RESP;
        end else begin
          // WAIT lasts LATENCY-1 cycles: counts LATENCY-2 down to 0.
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 2);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------
  logic issue_ok;
  always_comb begin
    issue_ok          = (state_q == ISSUE) && !acc_err;
    cmd_ready         = (state_q == IDLE);
    rsp_valid         = (state_q == RESP);
    ram_en            = issue_ok;
    // Reset gates the write strobe so a reset landing on ISSUE never commits.
    ram_wen           = issue_ok && wen_q && !reset;
    ram_wmask         = (issue_ok && wen_q) ? wstrb_to_mask(wstrb_q) : 64'h0;
    ram_wdata         = wdata_q;
    ram_idx           = addr_to_idx(addr_q, BASE_ADDR);
    rsp_payload_data  = rsp_data_q;
    rsp_payload_error = rsp_err_q;
  end

  // ---------------------------------------------------------------
  // Command and response data registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= 64'h0;
      wen_q      <= 1'b0;
      wdata_q    <= 64'h0;
      wstrb_q    <= 8'h0;
      size_q     <= 3'h0;
      data_q     <= 64'h0;
      err_q      <= 1'b0;
      rsp_data_q <= 64'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        addr_q  <= cmd_payload_addr;
        wen_q   <= cmd_payload_wen;
        wdata_q <= cmd_payload_wdata;
        wstrb_q <= cmd_payload_wstrb;
        size_q  <= cmd_payload_size;
      end
      if (state_q == ISSUE && !wen_q) begin
        data_q <= rdata_fresh;
        err_q  <= acc_err;
      end
      // With LATENCY=1 RESP follows ISSUE directly, so bypass the capture register.
      if (state_d == RESP) begin
        rsp_data_q <= (state_q == ISSUE) ? rdata_fresh : data_q;
        rsp_err_q  <= (state_q == ISSUE) ? acc_err     : err_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 1, 4 and 3 share one clock
// and a combinational RAM model; every check is an immediate assertion against hand-computed values.
module tb_dmem_responder;

  logic        clock;
  logic        reset       [3];
  logic        cmd_valid   [3];
  logic        cmd_ready   [3];
  logic [63:0] addr        [3];
  logic        wen         [3];
  logic [63:0] wdata       [3];
  logic [7:0]  wstrb       [3];
  logic [2:0]  size        [3];
  logic        rsp_valid   [3];
  logic [63:0] rsp_data    [3];
  logic        rsp_err     [3];
  logic        ram_en      [3];
  logic [27:0] ram_idx     [3];
  logic [63:0] ram_rdata   [3];
  logic        ram_wen     [3];
  logic [63:0] ram_wdata   [3];
  logic [63:0] ram_wmask   [3];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [63:0] ram_model(input logic [27:0] i);
    logic [63:0] v;
    case (i)
      28'd0:   v = 64'h0123_4567_89AB_CDEF;
      28'd1:   v = 64'hFEDC_BA98_7654_3210;
      28'd2:   v = 64'h1122_3344_5566_7788;
      default: v = 64'hA5A5_0000_0000_0000 | {36'h0, i};
    endcase
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 4 : 3))
    ) u_dut (
      .clock             (clock),
      .reset             (reset[g]),
      .cmd_valid         (cmd_valid[g]),
      .cmd_ready         (cmd_ready[g]),
      .cmd_payload_addr  (addr[g]),
      .cmd_payload_wen   (wen[g]),
      .cmd_payload_wdata (wdata[g]),
      .cmd_payload_wstrb (wstrb[g]),
      .cmd_payload_size  (size[g]),
      .rsp_valid         (rsp_valid[g]),
      .rsp_payload_data  (rsp_data[g]),
      .rsp_payload_error (rsp_err[g]),
      .ram_en            (ram_en[g]),
      .ram_idx           (ram_idx[g]),
      .ram_rdata         (ram_rdata[g]),
      .ram_wen           (ram_wen[g]),
      .ram_wdata         (ram_wdata[g]),
      .ram_wmask         (ram_wmask[g])
    );
    assign ram_rdata[g] = ram_model(ram_idx[g]);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cmd(input int u, input logic [63:0] a, input logic w,
                     input logic [63:0] d, input logic [7:0] s, input logic [2:0] sz);
    cmd_valid[u] = 1'b1;
    addr[u]      = a;
    wen[u]       = w;
    wdata[u]     = d;
    wstrb[u]     = s;
    size[u]      = sz;
  endtask

  // Single read on the LATENCY=1 instance: ISSUE, then RESP, then back to IDLE.
  task automatic do_read(input string tag, input logic [63:0] a, input logic [2:0] sz,
                         input logic exp_en, input logic [27:0] exp_idx,
                         input logic [63:0] exp_data, input logic exp_err);
    cmd(0, a, 1'b0, 64'h0, 8'h0, sz);
    step();
    chk({tag, "_ram_en"}, ram_en[0], exp_en);
    if (exp_en) chk({tag, "_ram_idx"}, ram_idx[0], exp_idx);
    cmd_valid[0] = 1'b0;
    step();
    chk({tag, "_rsp_valid"}, rsp_valid[0], 1'b1);
    chk({tag, "_rsp_data"},  rsp_data[0],  exp_data);
    chk({tag, "_rsp_err"},   rsp_err[0],   exp_err);
    step();
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; cmd_valid[i] = 1'b0; addr[i] = '0; wen[i] = 1'b0;
      wdata[i] = '0;   wstrb[i] = '0;       size[i] = '0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready[0], 1'b1);
    chk("rst_rsp_valid", rsp_valid[0], 1'b0);
    chk("rst_rsp_data",  rsp_data[0],  64'h0);
    chk("rst_rsp_err",   rsp_err[0],   1'b0);
    chk("rst_ram_en",    ram_en[0],    1'b0);
    chk("rst_ram_wen",   ram_wen[0],   1'b0);
    chk("rst_ram_wmask", ram_wmask[0], 64'h0);

    // LATENCY=1 read of word 2
    cmd(0, 64'h8000_0010, 1'b0, 64'h0, 8'h0, 3'd3);
    step();
    chk("rd1_ram_en",    ram_en[0],    1'b1);
    chk("rd1_ram_idx",   ram_idx[0],   28'd2);
    chk("rd1_ram_wen",   ram_wen[0],   1'b0);
    chk("rd1_cmd_ready", cmd_ready[0], 1'b0);
    chk("rd1_rsp_early", rsp_valid[0], 1'b0);
    cmd_valid[0] = 1'b0;
    step();
    chk("rd1_rsp_valid", rsp_valid[0], 1'b1);
    chk("rd1_rsp_data",  rsp_data[0],  64'h1122_3344_5566_7788);
    chk("rd1_rsp_err",   rsp_err[0],   1'b0);
    chk("rd1_cmd_ready2", cmd_ready[0], 1'b0);
    chk("rd1_ram_en_off", ram_en[0],   1'b0);
    step();
    chk("rd1_rsp_pulse", rsp_valid[0], 1'b0);
    chk("rd1_idle_ready", cmd_ready[0], 1'b1);
    chk("rd1_data_hold", rsp_data[0],  64'h1122_3344_5566_7788);

    // Write word 1, low four bytes
    cmd(0, 64'h8000_0008, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 3'd3);
    step();
    chk("wr_ram_en",    ram_en[0],    1'b1);
    chk("wr_ram_wen",   ram_wen[0],   1'b1);
    chk("wr_ram_idx",   ram_idx[0],   28'd1);
    chk("wr_ram_wmask", ram_wmask[0], 64'h0000_0000_FFFF_FFFF);
    chk("wr_ram_wdata", ram_wdata[0], 64'hAAAA_BBBB_CCCC_DDDD);
    cmd_valid[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid[0]) seen++;
      step();
      if (k == 0) begin
        chk("wr_ram_wen_off", ram_wen[0],   1'b0);
        chk("wr_wmask_off",   ram_wmask[0], 64'h0);
        chk("wr_ready_back",  cmd_ready[0], 1'b1);
      end
    end
    chk("wr_no_rsp", seen, 0);

    // LATENCY=4 back-to-back reads with cmd_valid held
    cmd(1, 64'h8000_0000, 1'b0, 64'h0, 8'h0, 3'd3);
    step();
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("l4_rsp_valid_k%0d", k), rsp_valid[1], (k == 5 || k == 11));
      chk($sformatf("l4_cmd_ready_k%0d", k), cmd_ready[1], (k == 6 || k == 12));
      chk($sformatf("l4_ram_en_k%0d", k),    ram_en[1],    (k == 1 || k == 7));
      if (k == 5)  chk("l4_data0", rsp_data[1], ram_model(28'd0));
      if (k == 11) chk("l4_data1", rsp_data[1], ram_model(28'd1));
      if (k == 7)  chk("l4_idx1",  ram_idx[1],  28'd1);
      if (k == 1)  addr[1] = 64'h8000_0008;
      if (k == 7)  cmd_valid[1] = 1'b0;
      step();
    end

    // Reset in the ISSUE cycle of a write
    cmd(0, 64'h8000_0018, 1'b1, 64'h5555_6666_7777_8888, 8'hFF, 3'd3);
    step();
    reset[0] = 1'b1;
    #1;
    chk("rstwr_ram_wen", ram_wen[0], 1'b0);
    cmd_valid[0] = 1'b0;
    step();
    reset[0] = 1'b0;
    chk("rstwr_cmd_ready", cmd_ready[0], 1'b1);
    chk("rstwr_ram_wen2",  ram_wen[0],   1'b0);
    chk("rstwr_ram_en",    ram_en[0],    1'b0);

    // Reset during WAIT of a LATENCY=3 read, then a clean read
    cmd(2, 64'h8000_0000, 1'b0, 64'h0, 8'h0, 3'd3);
    step();
    cmd_valid[2] = 1'b0;
    step();
    chk("rstwt_in_wait", cmd_ready[2], 1'b0);
    reset[2] = 1'b1;
    step();
    reset[2] = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid[2]) seen++;
      step();
    end
    chk("rstwt_no_rsp",  seen, 0);
    chk("rstwt_ready",   cmd_ready[2], 1'b1);
    cmd(2, 64'h8000_0010, 1'b0, 64'h0, 8'h0, 3'd3);
    step();
    cmd_valid[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("l3_rsp_valid_k%0d", k), rsp_valid[2], (k == 4));
      if (k == 4) chk("l3_data2", rsp_data[2], 64'h1122_3344_5566_7788);
      step();
    end

    // Address window and alignment behaviour
`ifdef DMEM_RANGE_CHECK_EN
    do_read("rc_below",   64'h7FFF_FFF8, 3'd3, 1'b0, 28'h0,       64'h0, 1'b1);
    do_read("rc_misal",   64'h8000_0004, 3'd3, 1'b0, 28'h0,       64'h0, 1'b1);
    do_read("rc_top_ok",  64'h87FF_FFF8, 3'd3, 1'b1, 28'hFF_FFFF, ram_model(28'hFF_FFFF), 1'b0);
    do_read("rc_past",    64'h8800_0000, 3'd3, 1'b0, 28'h0,       64'h0, 1'b1);
    do_read("rc_half_ok", 64'h8000_0012, 3'd1, 1'b1, 28'd2,       64'h1122_3344_5566_7788, 1'b0);
    do_read("rc_size4",   64'h8000_0010, 3'd4, 1'b0, 28'h0,       64'h0, 1'b1);
`else
    do_read("nc_below",   64'h7FFF_FFF8, 3'd3, 1'b1, 28'hFFF_FFFF, ram_model(28'hFFF_FFFF), 1'b0);
    do_read("nc_misal",   64'h8000_0004, 3'd3, 1'b1, 28'd0,        ram_model(28'd0), 1'b0);
`endif

    // Idle outputs of the read-only instances
    chk("l4_idle_wen",   ram_wen[1],   1'b0);
    chk("l4_idle_wmask", ram_wmask[1], 64'h0);
    chk("l4_idle_wdata", ram_wdata[1], 64'h0);
    chk("l4_idle_err",   rsp_err[1],   1'b0);
    chk("l3_idle_wen",   ram_wen[2],   1'b0);
    chk("l3_idle_wmask", ram_wmask[2], 64'h0);
    chk("l3_idle_wdata", ram_wdata[2], 64'h0);
    chk("l3_idle_err",   rsp_err[2],   1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
